regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL take widths from shared defines: `RegBus, 64, data width; `RegAddrBus, 5, register address width; `RstEnable, 1'b1, reset asserted level; `ZeroWord, 64'h0, zero data.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset (asserted when rst == `RstEnable)
- wb_rd_data  in  64  writeback data from the MEM/WB register
- wb_rd_addr  in  5  writeback destination register
- wb_rd_ena  in  1  writeback valid; 0 for bubbles
- iss_rd_addr  in  5  destination of the instruction leaving ID this cycle
- iss_rd_ena  in  1  issued instruction writes a register; caller gates with ID stall/flush
- rs1_addr, rs2_addr  in  5 each  read addresses
- rs1_ena, rs2_ena  in  1 each  read enables
- rs1_data, rs2_data  out  64 each  read data, combinational
- rs1_busy, rs2_busy  out  1 each  source has an uncommitted pending write
- wr_count  out  64  count of committed writes to x1..x31

Function
REQ-003 SHALL hold 31 writable 64-bit registers x1..x31; x0 SHALL always read `ZeroWord, never be busy, and ignore writes.
REQ-004 On posedge with wb_rd_ena=1 and wb_rd_addr!=0, SHALL write wb_rd_data to x[wb_rd_addr]; data is visible to a normal read on the next cycle.
REQ-005 rsN_data SHALL be `ZeroWord when rsN_ena=0 or rsN_addr=0; otherwise SHALL be x[rsN_addr], subject to REQ-013.
REQ-006 SHALL keep a 31-bit busy vector; on posedge, iss_rd_ena=1 with iss_rd_addr!=0 SHALL set busy[iss_rd_addr].
REQ-007 On posedge, wb_rd_ena=1 with wb_rd_addr!=0 SHALL clear busy[wb_rd_addr].
REQ-008 When set and clear target the same register in the same cycle, set SHALL win, because the newer writer is still in flight.
REQ-009 rsN_busy SHALL be busy[rsN_addr] when rsN_ena=1 and rsN_addr!=0; otherwise 0.
REQ-010 wr_count SHALL increment by 1 on each posedge where a write per REQ-004 occurs; it SHALL wrap from 2^64-1 to 0.
REQ-011 Both read ports SHALL operate independently; the same address on both ports SHALL return identical data and busy values.
REQ-012 Zero latency on reads (combinational) and one cycle for write, busy, and count updates; no backpressure; the block never stalls.

Reset
REQ-013 (bypass, see Configuration) SHALL NOT apply while rst is asserted.
REQ-014 On posedge with rst asserted, SHALL clear all registers to `ZeroWord, all busy bits to 0, and wr_count to 0; writes and issues that cycle SHALL be discarded.
REQ-015 While rst is asserted, rs1_data, rs2_data, rs1_busy, and rs2_busy SHALL read 0 regardless of inputs.
REQ-016 Reset asserted mid-operation SHALL drop pending busy state immediately; there is no drain.

Configuration
REQ-017 Macro REGFILE_BYPASS_EN:
- Defined: when wb_rd_ena=1, wb_rd_addr!=0 and wb_rd_addr==rsN_addr with rsN_ena=1, rsN_data SHALL be wb_rd_data in the same cycle and rsN_busy SHALL be 0 unless the same-cycle set of REQ-008 applies, in which case busy SHALL stay 1 from the next cycle.
- Undefined: rsN_data returns the stored value (old data until the next edge) and rsN_busy reflects the stored busy bit.

Verification
REQ-018 Reset, then read x5 on both ports -> rs1_data=rs2_data=0, busy=0, wr_count=0.
REQ-019 Write x0 with 64'hDEAD_BEEF (ena=1), then read x0 -> data 0, wr_count stays 0; write x7 with 64'h1234 -> next cycle rs1_data=64'h1234, wr_count=1.
REQ-020 Issue rd=x3 at cycle 1 -> rs2_busy=1 on x3 from cycle 2; WB x3 with 64'h55 at cycle 4 -> busy=0 and data 64'h55 from cycle 5.
REQ-021 Same cycle: iss x9 and WB x9 with 64'hA, busy previously 1 -> busy[9] stays 1, x9=64'hA.
REQ-022 With REGFILE_BYPASS_EN: WB x4 with 64'hFF while reading x4 -> rs1_data=64'hFF in the same cycle. Without the macro -> old value that cycle, 64'hFF next cycle.
REQ-023 Preload wr_count near wrap via 2^64-1 writes (force), one more write -> wr_count=0; assert rst mid-sequence with busy bits set -> all busy 0 and data 0 next cycle.

Source files
------------

// File: rtl/regfile.sv
// 31 x 64-bit integer register file with per-register busy (scoreboard) bits and a commit counter.
// Optional define REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
`ifndef RegBus
`define RegBus 64
`endif
`ifndef RegAddrBus
`define RegAddrBus 5
`endif
`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef ZeroWord
`define ZeroWord 64'h0
`endif

module regfile (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`RegBus-1:0]     wb_rd_data,
  input  logic [`RegAddrBus-1:0] wb_rd_addr,
  input  logic                   wb_rd_ena,
  input  logic [`RegAddrBus-1:0] iss_rd_addr,
  input  logic                   iss_rd_ena,
  input  logic [`RegAddrBus-1:0] rs1_addr,
  input  logic [`RegAddrBus-1:0] rs2_addr,
  input  logic                   rs1_ena,
  input  logic                   rs2_ena,
  output logic [`RegBus-1:0]     rs1_data,
  output logic [`RegBus-1:0]     rs2_data,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [`RegBus-1:0]     wr_count
);

  logic [`RegBus-1:0] regs_q [1:31];
  logic [31:1]        busy_q, busy_d;
  logic [`RegBus-1:0] wr_count_q, wr_count_d;
  logic               wb_wr, iss_set, in_rst;

  assign in_rst  = (rst == `RstEnable);
  assign wb_wr   = wb_rd_ena && (wb_rd_addr != '0);
  assign iss_set = iss_rd_ena && (iss_rd_addr != '0);

  // Set is applied after clear so a newer in-flight writer keeps the register busy.
  always_comb begin
    busy_d     = busy_q;
    wr_count_d = wr_count_q;
    if (wb_wr) begin
      busy_d[wb_rd_addr] = 1'b0;
      wr_count_d         = wr_count_q + 64'd1;
    end
    if (iss_set) begin
      busy_d[iss_rd_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= `ZeroWord;
      end
      busy_q     <= '0;
      wr_count_q <= '0;
    end else begin
      if (wb_wr) begin
        regs_q[wb_rd_addr] <= wb_rd_data;
      end
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
    end
  end

  function automatic logic [`RegBus-1:0] rd_data(input logic ena,
                                                  input logic [`RegAddrBus-1:0] addr);
    logic [`RegBus-1:0] v;
    v = `ZeroWord;
    if (!in_rst && ena && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_wr && (wb_rd_addr == addr)) begin
        v = wb_rd_data;
      end else begin
        v = regs_q[addr];
      end
`else
      v = regs_q[addr];
`endif
    end
    return v;
  endfunction

  // With forwarding, a same-cycle writeback satisfies the reader; any new issue shows up next cycle.
  function automatic logic rd_busy(input logic ena,
                                   input logic [`RegAddrBus-1:0] addr);
    logic v;
    v = 1'b0;
    if (!in_rst && ena && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_wr && (wb_rd_addr == addr)) begin
        v = 1'b0;
      end else begin
        v = busy_q[addr];
      end
`else
      v = busy_q[addr];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rs1_data = rd_data(rs1_ena, rs1_addr);
    rs2_data = rd_data(rs2_ena, rs2_addr);
    rs1_busy = rd_busy(rs1_ena, rs1_addr);
    rs2_busy = rd_busy(rs2_ena, rs2_addr);
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN when it is defined.
`timescale 1ns/1ps
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] wb_rd_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_ena;
  logic [4:0]  iss_rd_addr;
  logic        iss_rd_ena;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_ena, rs2_ena;
  logic [63:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic [63:0] wr_count;

  int n_vec  = 0;
  int n_miss = 0;

  regfile dut (
    .clk(clk), .rst(rst),
    .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_ena(wb_rd_ena),
    .iss_rd_addr(iss_rd_addr), .iss_rd_ena(iss_rd_ena),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_ena(rs1_ena), .rs2_ena(rs2_ena),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [63:0] d);
    wb_rd_ena = en; wb_rd_addr = a; wb_rd_data = d;
  endtask

  initial begin
    logic [63:0] exp_same;
    rst = 1'b1;
    wb(1'b0, 5'd0, 64'h0);
    iss_rd_ena = 1'b0; iss_rd_addr = 5'd0;
    rs1_ena = 1'b0; rs2_ena = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    rs1_ena = 1'b1; rs2_ena = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd5; #1;
    chk("rst_rs1_data", rs1_data, 64'h0);
    chk("rst_rs2_data", rs2_data, 64'h0);
    chk("rst_rs1_busy", {63'h0, rs1_busy}, 64'h0);
    chk("rst_rs2_busy", {63'h0, rs2_busy}, 64'h0);
    chk("rst_wr_count", wr_count, 64'h0);

    // x0 ignores writes; x7 write visible next cycle
    wb(1'b1, 5'd0, 64'hDEAD_BEEF); tick();
    wb(1'b0, 5'd0, 64'h0); rs1_addr = 5'd0; #1;
    chk("x0_data", rs1_data, 64'h0);
    chk("x0_count", wr_count, 64'h0);
    wb(1'b1, 5'd7, 64'h1234); tick();
    wb(1'b0, 5'd0, 64'h0); rs1_addr = 5'd7; #1;
    chk("x7_data", rs1_data, 64'h1234);
    chk("x7_count", wr_count, 64'd1);

    // Issue x3, busy from next cycle, cleared by writeback
    iss_rd_ena = 1'b1; iss_rd_addr = 5'd3; rs2_addr = 5'd3; #1;
    chk("x3_busy_pre", {63'h0, rs2_busy}, 64'h0);
    tick();
    iss_rd_ena = 1'b0; #1;
    chk("x3_busy_c2", {63'h0, rs2_busy}, 64'd1);
    tick(); tick();
    chk("x3_busy_c4", {63'h0, rs2_busy}, 64'd1);
    wb(1'b1, 5'd3, 64'h55); #1;
`ifdef REGFILE_BYPASS_EN
    chk("x3_wb_busy", {63'h0, rs2_busy}, 64'h0);
    chk("x3_wb_data", rs2_data, 64'h55);
`else
    chk("x3_wb_busy", {63'h0, rs2_busy}, 64'd1);
    chk("x3_wb_data", rs2_data, 64'h0);
`endif
    tick();
    wb(1'b0, 5'd0, 64'h0); #1;
    chk("x3_busy_c5", {63'h0, rs2_busy}, 64'h0);
    chk("x3_data_c5", rs2_data, 64'h55);
    chk("x3_count", wr_count, 64'd2);

    // Same-cycle set and clear on x9: set wins
    iss_rd_ena = 1'b1; iss_rd_addr = 5'd9; tick();
    wb(1'b1, 5'd9, 64'hA); tick();
    iss_rd_ena = 1'b0; wb(1'b0, 5'd0, 64'h0);
    rs1_addr = 5'd9; rs2_addr = 5'd9; #1;
    chk("x9_busy", {63'h0, rs1_busy}, 64'd1);
    chk("x9_data", rs1_data, 64'hA);
    chk("x9_rs2_data", rs2_data, 64'hA);
    chk("x9_rs2_busy", {63'h0, rs2_busy}, 64'd1);
    chk("x9_count", wr_count, 64'd3);
    rs1_ena = 1'b0; #1;
    chk("dis_data", rs1_data, 64'h0);
    chk("dis_busy", {63'h0, rs1_busy}, 64'h0);
    rs1_ena = 1'b1;

    // Write x4 while reading it
    rs1_addr = 5'd4; wb(1'b1, 5'd4, 64'hFF); #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 64'hFF;
`else
    exp_same = 64'h0;
`endif
    chk("x4_same_cycle", rs1_data, exp_same);
    tick();
    wb(1'b0, 5'd0, 64'h0); #1;
    chk("x4_next_cycle", rs1_data, 64'hFF);
    chk("x4_count", wr_count, 64'd4);

    // Counter wrap
    force dut.wr_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    chk("wrap_preload", wr_count, 64'hFFFF_FFFF_FFFF_FFFF);
    wb(1'b1, 5'd5, 64'h77); tick();
    wb(1'b0, 5'd0, 64'h0); #1;
    chk("wrap_zero", wr_count, 64'h0);

    // Reset mid-operation with busy bits set; writes/issues during reset discarded
    iss_rd_ena = 1'b1; iss_rd_addr = 5'd10; tick();
    iss_rd_addr = 5'd11; tick();
    iss_rd_ena = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd11; #1;
    chk("pre_rst_busy10", {63'h0, rs1_busy}, 64'd1);
    chk("pre_rst_busy11", {63'h0, rs2_busy}, 64'd1);
    rs1_addr = 5'd7; #1;
    chk("pre_rst_x7", rs1_data, 64'h1234);
    rst = 1'b1; wb(1'b1, 5'd12, 64'hCAFE); iss_rd_ena = 1'b1; iss_rd_addr = 5'd13; #1;
    chk("in_rst_x7", rs1_data, 64'h0);
    chk("in_rst_busy11", {63'h0, rs2_busy}, 64'h0);
    tick();
    rst = 1'b0; wb(1'b0, 5'd0, 64'h0); iss_rd_ena = 1'b0; #1;
    chk("post_rst_x7", rs1_data, 64'h0);
    chk("post_rst_busy11", {63'h0, rs2_busy}, 64'h0);
    chk("post_rst_count", wr_count, 64'h0);
    rs1_addr = 5'd12; rs2_addr = 5'd13; #1;
    chk("post_rst_x12", rs1_data, 64'h0);
    chk("post_rst_busy13", {63'h0, rs2_busy}, 64'h0);
    wb(1'b1, 5'd7, 64'h9); tick();
    wb(1'b0, 5'd0, 64'h0); rs1_addr = 5'd7; #1;
    chk("post_rst_write", rs1_data, 64'h9);
    chk("post_rst_count1", wr_count, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
